// File: rtl/i2c_target.sv
// i2c_target: I2C target engine with an 8-bit register-pointer interface.
// SCL/SDA are oversampled on clk. SDA is only ever pulled low (open drain)
// and SCL is never driven, so there is no clock stretching.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h1D,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       reg_rd,
    output logic       busy,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_RX       = 4'd5,
        S_RX_ACK   = 4'd6,
        S_TX       = 4'd7,
        S_TX_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // Input synchronizers and one-cycle-delayed copies for edge detection.
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    // FSM and datapath registers.
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx_shift;
    logic       r_rw;
    logic       r_ack;
    logic       r_sda_oe;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_reg_rd;
    logic       r_busy;
    logic       r_inc_pend;

    // Next-state values computed by the combinational FSM process.
    state_t     w_nx_state;
    logic [3:0] w_nx_bit_cnt;
    logic [7:0] w_nx_shift;
    logic [7:0] w_nx_tx_shift;
    logic       w_nx_rw;
    logic       w_nx_ack;
    logic       w_nx_sda_oe;
    logic [7:0] w_nx_reg_addr;
    logic [7:0] w_nx_reg_wdata;
    logic       w_nx_reg_we;
    logic       w_nx_reg_rd;
    logic       w_nx_busy;
    logic       w_nx_inc_pend;

    // Bring the asynchronous bus lines into the clk domain; idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & ~w_sda & r_sda_prev;
    assign w_stop     = w_scl & r_scl_prev & w_sda & ~r_sda_prev;

    // Register the FSM state and all datapath values it controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_tx_shift  <= 8'd0;
            r_rw        <= 1'b0;
            r_ack       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_reg_wdata <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_busy      <= 1'b0;
            r_inc_pend  <= 1'b0;
        end else begin
            r_state     <= w_nx_state;
            r_bit_cnt   <= w_nx_bit_cnt;
            r_shift     <= w_nx_shift;
            r_tx_shift  <= w_nx_tx_shift;
            r_rw        <= w_nx_rw;
            r_ack       <= w_nx_ack;
            r_sda_oe    <= w_nx_sda_oe;
            r_reg_addr  <= w_nx_reg_addr;
            r_reg_wdata <= w_nx_reg_wdata;
            r_reg_we    <= w_nx_reg_we;
            r_reg_rd    <= w_nx_reg_rd;
            r_busy      <= w_nx_busy;
            r_inc_pend  <= w_nx_inc_pend;
        end
    end

    // Protocol FSM: START/STOP override everything, otherwise act on SCL edges.
    always_comb begin
        w_nx_state     = r_state;
        w_nx_bit_cnt   = r_bit_cnt;
        w_nx_shift     = r_shift;
        w_nx_tx_shift  = r_tx_shift;
        w_nx_rw        = r_rw;
        w_nx_ack       = r_ack;
        w_nx_sda_oe    = r_sda_oe;
        w_nx_reg_addr  = r_reg_addr;
        w_nx_reg_wdata = r_reg_wdata;
        w_nx_reg_we    = 1'b0;
        w_nx_reg_rd    = 1'b0;
        w_nx_busy      = r_busy;
        w_nx_inc_pend  = 1'b0;

        // Post-write pointer increment lands the cycle after the write strobe.
        if (r_inc_pend) begin
            w_nx_reg_addr = r_reg_addr + 8'd1;
        end

        // The read strobe cycle: capture the byte and present its MSB.
        if (r_reg_rd && (r_state == S_TX)) begin
            w_nx_tx_shift = reg_rdata;
            w_nx_sda_oe   = ~reg_rdata[7];
            w_nx_bit_cnt  = 4'd1;
        end

        if (w_start) begin
            w_nx_state   = S_ADDR;
            w_nx_bit_cnt = 4'd0;
            w_nx_sda_oe  = 1'b0;
            w_nx_busy    = 1'b1;
        end else if (w_stop) begin
            w_nx_state  = S_IDLE;
            w_nx_sda_oe = 1'b0;
            w_nx_busy   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nx_sda_oe = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_nx_shift   = {r_shift[6:0], w_sda};
                        w_nx_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        if (r_shift[7:1] == TARGET_ADDR) begin
                            w_nx_state  = S_ADDR_ACK;
                            w_nx_rw     = r_shift[0];
                            w_nx_sda_oe = 1'b1;
                        end else begin
                            w_nx_state = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_rw) begin
                            w_nx_state   = S_PTR;
                            w_nx_sda_oe  = 1'b0;
                            w_nx_bit_cnt = 4'd0;
                        end else begin
                            w_nx_state  = S_TX;
                            w_nx_reg_rd = 1'b1;
                        end
                    end
                end
                S_PTR: begin
                    if (w_scl_rise) begin
                        w_nx_shift   = {r_shift[6:0], w_sda};
                        w_nx_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_nx_reg_addr = r_shift;
                        w_nx_sda_oe   = 1'b1;
                        w_nx_state    = S_PTR_ACK;
                    end
                end
                S_PTR_ACK, S_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_nx_state   = S_RX;
                        w_nx_sda_oe  = 1'b0;
                        w_nx_bit_cnt = 4'd0;
                    end
                end
                S_RX: begin
                    if (w_scl_rise) begin
                        w_nx_shift   = {r_shift[6:0], w_sda};
                        w_nx_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_nx_reg_wdata = r_shift;
                        w_nx_reg_we    = 1'b1;
                        w_nx_inc_pend  = 1'b1;
                        w_nx_sda_oe    = 1'b1;
                        w_nx_state     = S_RX_ACK;
                    end
                end
                S_TX: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_nx_sda_oe   = 1'b0;
                            w_nx_reg_addr = r_reg_addr + 8'd1;
                            w_nx_state    = S_TX_ACK;
                        end else begin
                            w_nx_tx_shift = {r_tx_shift[6:0], 1'b0};
                            w_nx_sda_oe   = ~r_tx_shift[6];
                            w_nx_bit_cnt  = r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    w_nx_sda_oe = 1'b0;
                    if (w_scl_rise) begin
                        w_nx_ack = w_sda;
                    end else if (w_scl_fall) begin
                        if (!r_ack) begin
                            w_nx_reg_rd = 1'b1;
                            w_nx_state  = S_TX;
                        end else begin
                            w_nx_state = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    w_nx_sda_oe = 1'b0;
                end
                default: begin
                    w_nx_state  = S_IDLE;
                    w_nx_sda_oe = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_rd    = r_reg_rd;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
